// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, driving datapath selects and write enables.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       br_taken,
   output logic       pc_we,
   output logic       ir_we,
   output logic       mem_re,
   output logic       mem_we,
   output logic       rf_wren,
   output logic       adr_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] result_src,
   output logic       retire,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WR   = 4'd4,
      WB_MEM   = 4'd5,
      EXEC_R   = 4'd6,
      EXEC_I   = 4'd7,
      WB_ALU   = 4'd8,
      BRANCH   = 4'd9,
      JALR     = 4'd10,
      JAL      = 4'd11,
      LUI      = 4'd12,
      TRAP     = 4'd13
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   state_t state_q, state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= FETCH;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      rf_wren    = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      result_src = 2'b00;
      retire     = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         FETCH: begin
            mem_re     = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (mem_ready) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b01;
            case (opcode)
               OP_R:               state_d = EXEC_R;
               OP_I:               state_d = EXEC_I;
               OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
               OP_BRANCH:          state_d = BRANCH;
               OP_JAL:             state_d = JAL;
               OP_JALR:            state_d = JALR;
               OP_LUI:             state_d = LUI;
               OP_AUIPC:           state_d = WB_ALU;
               default:            state_d = TRAP;
            endcase
         end
         MEM_ADDR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            mem_re  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_d = WB_MEM;
         end
         WB_MEM: begin
            result_src = 2'b01;
            rf_wren    = 1'b1;
            retire     = 1'b1;
            state_d    = FETCH;
         end
         MEM_WR: begin
            mem_we  = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = FETCH;
            end
         end
         EXEC_R: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b10;
            state_d   = WB_ALU;
         end
         EXEC_I: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            alu_op    = 2'b10;
            state_d   = WB_ALU;
         end
         LUI: begin
            alu_src_a = 2'b11;
            alu_src_b = 2'b01;
            state_d   = WB_ALU;
         end
         WB_ALU: begin
            rf_wren = 1'b1;
            retire  = 1'b1;
            state_d = FETCH;
         end
         BRANCH: begin
            alu_src_a = 2'b10;
            alu_op    = 2'b01;
            pc_we     = br_taken;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         JALR: begin
            alu_src_a = 2'b10;
            alu_src_b = 2'b01;
            state_d   = JAL;
         end
         JAL: begin
            alu_src_a = 2'b01;
            alu_src_b = 2'b10;
            pc_we     = 1'b1;
            state_d   = WB_ALU;
         end
         TRAP: begin
            illegal = 1'b1;
         end
         default: state_d = FETCH;
      endcase
      // Enables must be quiet for the whole reset pulse, not just after the edge.
      if (rst) begin
         pc_we   = 1'b0;
         ir_we   = 1'b0;
         mem_re  = 1'b0;
         mem_we  = 1'b0;
         rf_wren = 1'b0;
         retire  = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: each step pushes the expected output
// vector into a scoreboard queue, which is popped and compared mid-cycle.
module tb_multicycle_ctrl;

   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2,
                          S_MEM_RD = 4'd3, S_MEM_WR = 4'd4, S_WB_MEM = 4'd5,
                          S_EXEC_R = 4'd6, S_EXEC_I = 4'd7, S_WB_ALU = 4'd8,
                          S_BRANCH = 4'd9, S_JALR = 4'd10, S_JAL = 4'd11,
                          S_LUI = 4'd12, S_TRAP = 4'd13;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                          OP_SW = 7'b0100011, OP_BEQ = 7'b1100011, OP_JALR = 7'b1100111,
                          OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_BAD = 7'b0000000;

   // sel = {adr_src, alu_src_a, alu_src_b, alu_op, result_src}
   localparam logic [8:0] SEL_FETCH  = 9'b0_00_10_00_10;
   localparam logic [8:0] SEL_DECODE = 9'b0_01_01_00_00;
   localparam logic [8:0] SEL_EXEC_R = 9'b0_10_00_10_00;
   localparam logic [8:0] SEL_EXEC_I = 9'b0_10_01_10_00;
   localparam logic [8:0] SEL_RS1IMM = 9'b0_10_01_00_00;
   localparam logic [8:0] SEL_MEMADR = 9'b1_00_00_00_00;
   localparam logic [8:0] SEL_WBMEM  = 9'b0_00_00_00_01;
   localparam logic [8:0] SEL_BRANCH = 9'b0_10_00_01_00;
   localparam logic [8:0] SEL_JAL    = 9'b0_01_10_00_00;
   localparam logic [8:0] SEL_LUI    = 9'b0_11_01_00_00;
   localparam logic [8:0] SEL_ZERO   = 9'b0_00_00_00_00;

   // en = {pc_we, ir_we, mem_re, mem_we, rf_wren, retire}
   localparam logic [5:0] EN_NONE   = 6'b000000;
   localparam logic [5:0] EN_FWAIT  = 6'b001000;
   localparam logic [5:0] EN_FDONE  = 6'b111000;
   localparam logic [5:0] EN_WB     = 6'b000011;
   localparam logic [5:0] EN_WWAIT  = 6'b000100;
   localparam logic [5:0] EN_WDONE  = 6'b000101;
   localparam logic [5:0] EN_BR_NT  = 6'b000001;
   localparam logic [5:0] EN_BR_T   = 6'b100001;
   localparam logic [5:0] EN_PC     = 6'b100000;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic       mem_ready, br_taken;
   logic       pc_we, ir_we, mem_re, mem_we, rf_wren, adr_src, retire, illegal;
   logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
   logic [3:0] state;

   typedef struct {
      string       tag;
      logic [19:0] vec;
   } exp_t;

   exp_t scoreboard[$];
   int   checks = 0;
   int   failures = 0;

   multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .br_taken(br_taken),
      .pc_we(pc_we), .ir_we(ir_we), .mem_re(mem_re), .mem_we(mem_we), .rf_wren(rf_wren),
      .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .result_src(result_src), .retire(retire), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   // Pops the oldest expectation and compares it against the live outputs.
   task automatic checkOutput();
      exp_t        e;
      logic [19:0] act;
      act = {state, pc_we, ir_we, mem_re, mem_we, rf_wren, retire,
             adr_src, alu_src_a, alu_src_b, alu_op, result_src, illegal};
      checks++;
      if (scoreboard.size() == 0) begin
         failures++;
         $error("[TB] FAIL scoreboard_underflow observed=%h expected=<entry>", act);
      end else begin
         e = scoreboard.pop_front();
         assert (act === e.vec) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", e.tag, act, e.vec);
         end
      end
   endtask

   // Drives one cycle of inputs, queues the expected outputs, checks mid-cycle.
   task automatic applyStimulus(input logic r, input logic [6:0] op, input logic mr,
                                input logic bt, input logic [3:0] st, input logic [5:0] en,
                                input logic [8:0] sel, input logic ill, input string tag);
      exp_t e;
      @(posedge clk);
      #1;
      rst       = r;
      opcode    = op;
      mem_ready = mr;
      br_taken  = bt;
      e.tag = tag;
      e.vec = {st, en, sel, ill};
      scoreboard.push_back(e);
      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1; opcode = OP_R; mem_ready = 1'b1; br_taken = 1'b0;

      for (int i = 0; i < 3; i++)
         applyStimulus(1, OP_R, 1, 0, S_FETCH, EN_NONE, SEL_FETCH, 0, "reset_hold");
      applyStimulus(0, OP_R, 0, 0, S_FETCH, EN_FWAIT, SEL_FETCH, 0, "reset_release");

      applyStimulus(0, OP_R, 1, 0, S_FETCH,  EN_FDONE, SEL_FETCH,  0, "add_fetch");
      applyStimulus(0, OP_R, 1, 0, S_DECODE, EN_NONE,  SEL_DECODE, 0, "add_decode");
      applyStimulus(0, OP_R, 1, 0, S_EXEC_R, EN_NONE,  SEL_EXEC_R, 0, "add_exec");
      applyStimulus(0, OP_R, 1, 0, S_WB_ALU, EN_WB,    SEL_ZERO,   0, "add_wb");

      for (int i = 0; i < 2; i++)
         applyStimulus(0, OP_LW, 0, 0, S_FETCH, EN_FWAIT, SEL_FETCH, 0, "lw_fetch_wait");
      applyStimulus(0, OP_LW, 1, 0, S_FETCH,    EN_FDONE, SEL_FETCH,  0, "lw_fetch");
      applyStimulus(0, OP_LW, 1, 0, S_DECODE,   EN_NONE,  SEL_DECODE, 0, "lw_decode");
      applyStimulus(0, OP_LW, 1, 0, S_MEM_ADDR, EN_NONE,  SEL_RS1IMM, 0, "lw_addr");
      for (int i = 0; i < 2; i++)
         applyStimulus(0, OP_LW, 0, 0, S_MEM_RD, EN_FWAIT, SEL_MEMADR, 0, "lw_rd_wait");
      applyStimulus(0, OP_LW, 1, 0, S_MEM_RD, EN_FWAIT, SEL_MEMADR, 0, "lw_rd");
      applyStimulus(0, OP_LW, 1, 0, S_WB_MEM, EN_WB,    SEL_WBMEM,  0, "lw_wb");

      applyStimulus(0, OP_SW, 1, 0, S_FETCH,    EN_FDONE, SEL_FETCH,  0, "sw_fetch");
      applyStimulus(0, OP_SW, 1, 0, S_DECODE,   EN_NONE,  SEL_DECODE, 0, "sw_decode");
      applyStimulus(0, OP_SW, 1, 0, S_MEM_ADDR, EN_NONE,  SEL_RS1IMM, 0, "sw_addr");
      applyStimulus(0, OP_SW, 0, 0, S_MEM_WR,   EN_WWAIT, SEL_MEMADR, 0, "sw_wr_wait");
      applyStimulus(0, OP_SW, 1, 0, S_MEM_WR,   EN_WDONE, SEL_MEMADR, 0, "sw_wr");

      applyStimulus(0, OP_BEQ, 1, 0, S_FETCH,  EN_FDONE, SEL_FETCH,  0, "beq_nt_fetch");
      applyStimulus(0, OP_BEQ, 1, 0, S_DECODE, EN_NONE,  SEL_DECODE, 0, "beq_nt_decode");
      applyStimulus(0, OP_BEQ, 1, 0, S_BRANCH, EN_BR_NT, SEL_BRANCH, 0, "beq_nt_branch");
      applyStimulus(0, OP_BEQ, 1, 1, S_FETCH,  EN_FDONE, SEL_FETCH,  0, "beq_t_fetch");
      applyStimulus(0, OP_BEQ, 1, 1, S_DECODE, EN_NONE,  SEL_DECODE, 0, "beq_t_decode");
      applyStimulus(0, OP_BEQ, 1, 1, S_BRANCH, EN_BR_T,  SEL_BRANCH, 0, "beq_t_branch");

      applyStimulus(0, OP_JALR, 1, 0, S_FETCH,  EN_FDONE, SEL_FETCH,  0, "jalr_fetch");
      applyStimulus(0, OP_JALR, 1, 0, S_DECODE, EN_NONE,  SEL_DECODE, 0, "jalr_decode");
      applyStimulus(0, OP_JALR, 1, 0, S_JALR,   EN_NONE,  SEL_RS1IMM, 0, "jalr_jalr");
      applyStimulus(0, OP_JALR, 1, 0, S_JAL,    EN_PC,    SEL_JAL,    0, "jalr_jal");
      applyStimulus(0, OP_JALR, 1, 0, S_WB_ALU, EN_WB,    SEL_ZERO,   0, "jalr_wb");

      applyStimulus(0, OP_AUIPC, 1, 0, S_FETCH,  EN_FDONE, SEL_FETCH,  0, "auipc_fetch");
      applyStimulus(0, OP_AUIPC, 1, 0, S_DECODE, EN_NONE,  SEL_DECODE, 0, "auipc_decode");
      applyStimulus(0, OP_AUIPC, 1, 0, S_WB_ALU, EN_WB,    SEL_ZERO,   0, "auipc_wb");

      applyStimulus(0, OP_LUI, 1, 0, S_FETCH,  EN_FDONE, SEL_FETCH,  0, "lui_fetch");
      applyStimulus(0, OP_LUI, 1, 0, S_DECODE, EN_NONE,  SEL_DECODE, 0, "lui_decode");
      applyStimulus(0, OP_LUI, 1, 0, S_LUI,    EN_NONE,  SEL_LUI,    0, "lui_exec");
      applyStimulus(0, OP_LUI, 1, 0, S_WB_ALU, EN_WB,    SEL_ZERO,   0, "lui_wb");

      applyStimulus(0, OP_I, 1, 0, S_FETCH,  EN_FDONE, SEL_FETCH,  0, "addi_fetch");
      applyStimulus(0, OP_I, 1, 0, S_DECODE, EN_NONE,  SEL_DECODE, 0, "addi_decode");
      applyStimulus(0, OP_I, 1, 0, S_EXEC_I, EN_NONE,  SEL_EXEC_I, 0, "addi_exec");
      applyStimulus(1, OP_I, 1, 0, S_FETCH,  EN_NONE,  SEL_FETCH,  0, "addi_abort_reset");

      applyStimulus(0, OP_BAD, 1, 0, S_FETCH,  EN_FDONE, SEL_FETCH,  0, "bad_fetch");
      applyStimulus(0, OP_BAD, 1, 0, S_DECODE, EN_NONE,  SEL_DECODE, 0, "bad_decode");
      for (int i = 0; i < 11; i++)
         applyStimulus(0, OP_BAD, i[0], 1, S_TRAP, EN_NONE, SEL_ZERO, 1, "trap_hold");
      applyStimulus(1, OP_BAD, 1, 0, S_FETCH, EN_NONE,  SEL_FETCH, 0, "trap_reset");
      applyStimulus(0, OP_BAD, 0, 0, S_FETCH, EN_FWAIT, SEL_FETCH, 0, "trap_release");

      checks++;
      assert (scoreboard.size() == 0) else begin
         failures++;
         $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", scoreboard.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
